status_flags_unit: RTL and testbench



---
 rtl/cpu6502_pkg.sv | 29 ++
 rtl/int_sync.sv | 31 +++
 rtl/status_flags_unit.sv | 106 ++++++++++
 tb/tb_status_flags_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: status flag bit positions, reset value of P and
// the flag-enable masks the ALU drives on alu_flags_ena.
package cpu6502_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  localparam logic [7:0] P_RESET = 8'h34;

  // Bits that are physically stored in P (B and U are synthesized on read).
  localparam logic [7:0] MASK_STORED = 8'hCF;

  localparam logic [7:0] MASK_C    = 8'h01;
  localparam logic [7:0] MASK_Z    = 8'h02;
  localparam logic [7:0] MASK_I    = 8'h04;
  localparam logic [7:0] MASK_D    = 8'h08;
  localparam logic [7:0] MASK_V    = 8'h40;
  localparam logic [7:0] MASK_NZ   = 8'h82;
  localparam logic [7:0] MASK_NZC  = 8'h83;
  localparam logic [7:0] MASK_NVZ  = 8'hC2;
  localparam logic [7:0] MASK_NVZC = 8'hC3;

endpackage

// File: rtl/int_sync.sv
// Interrupt pin synchronizer: SYNC_STAGES-deep flop chain preset to 1
// (inactive), plus a registered copy of the synced value so a falling edge
// can be flagged for exactly one cycle.
module int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic synced,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the pin through the chain and remember last cycle's synced value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign synced = chain[SYNC_STAGES-1];
  assign fall   = prev & ~chain[SYNC_STAGES-1];

endmodule

// File: rtl/status_flags_unit.sv
// 6502 status register (P) with ALU flag merge, stack push/pull images,
// interrupt-entry side effects, one-instruction-delayed IRQ masking and
// NMI falling-edge latching.
// Build option: STATUS_FLAGS_CMOS_DCLR_EN -- when defined (65C02), interrupt
// entry also clears D; otherwise (NMOS) D is left alone.
module status_flags_unit
  import cpu6502_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] alu_flags_out,
  input  logic [7:0] alu_flags_ena,
  input  logic       flag_update,
  input  logic       p_load,
  input  logic [7:0] p_load_data,
  input  logic       p_push_brk,
  output logic [7:0] p_push_data,
  output logic [7:0] flags_in,
  input  logic       int_entry,
  input  logic       int_ack_nmi,
  input  logic       instr_boundary,
  input  logic       irq_n,
  input  logic       nmi_n,
  output logic       irq_req,
  output logic       nmi_req
);

  // Stored bits in order {N,V,D,I,Z,C}.
  logic [5:0] p_bits;
  logic [7:0] p_view;
  logic [7:0] p_next;
  logic [7:0] ena_stored;
  logic       irq_mask;
  logic       nmi_pending;
  logic       irq_synced;
  logic       irq_fall_unused;
  logic       nmi_synced_unused;
  logic       nmi_fall;
  logic       unused_bits;

  assign p_view = {p_bits[5:4], 2'b11, p_bits[3:0]};

  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (irq_n),
    .synced  (irq_synced),
    .fall    (irq_fall_unused)
  );

  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (nmi_n),
    .synced  (nmi_synced_unused),
    .fall    (nmi_fall)
  );

  assign ena_stored = alu_flags_ena & MASK_STORED;

  // Next P: stack pull beats ALU merge; interrupt entry is layered on top.
  always_comb begin
    p_next = p_view;
    if (p_load) begin
      p_next = p_load_data;
    end else if (flag_update) begin
      p_next = (p_view & ~ena_stored) | (alu_flags_out & ena_stored);
    end
    if (int_entry) begin
      p_next[FLAG_I] = 1'b1;
`ifdef STATUS_FLAGS_CMOS_DCLR_EN
      p_next[FLAG_D] = 1'b0;
`endif
    end
  end

  // P storage, IRQ mask sampled at opcode fetch, NMI pending latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_bits      <= {P_RESET[FLAG_N], P_RESET[FLAG_V], P_RESET[FLAG_D:FLAG_C]};
      irq_mask    <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      p_bits <= {p_next[FLAG_N], p_next[FLAG_V], p_next[FLAG_D:FLAG_C]};
      if (instr_boundary) begin
        irq_mask <= p_view[FLAG_I];
      end
      // A new edge wins over an acknowledge on the same clock.
      if (nmi_fall) begin
        nmi_pending <= 1'b1;
      end else if (int_ack_nmi) begin
        nmi_pending <= 1'b0;
      end
    end
  end

  assign flags_in    = p_view;
  assign p_push_data = {p_view[FLAG_N], p_view[FLAG_V], 1'b1, p_push_brk, p_view[FLAG_D:FLAG_C]};
  assign irq_req     = ~irq_synced & ~irq_mask;
  assign nmi_req     = nmi_pending;

  assign unused_bits = ^{p_next[FLAG_U:FLAG_B]};

endmodule

// File: tb/tb_status_flags_unit.sv
module tb_status_flags_unit;
  import cpu6502_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] alu_flags_out;
  logic [7:0] alu_flags_ena;
  logic       flag_update;
  logic       p_load;
  logic [7:0] p_load_data;
  logic       p_push_brk;
  logic [7:0] p_push_data;
  logic [7:0] flags_in;
  logic       int_entry;
  logic       int_ack_nmi;
  logic       instr_boundary;
  logic       irq_n;
  logic       nmi_n;
  logic       irq_req;
  logic       nmi_req;

  always #5 clk = ~clk;

  status_flags_unit #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .alu_flags_out  (alu_flags_out),
    .alu_flags_ena  (alu_flags_ena),
    .flag_update    (flag_update),
    .p_load         (p_load),
    .p_load_data    (p_load_data),
    .p_push_brk     (p_push_brk),
    .p_push_data    (p_push_data),
    .flags_in       (flags_in),
    .int_entry      (int_entry),
    .int_ack_nmi    (int_ack_nmi),
    .instr_boundary (instr_boundary),
    .irq_n          (irq_n),
    .nmi_n          (nmi_n),
    .irq_req        (irq_req),
    .nmi_req        (nmi_req)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: P as the full byte seen on flags_in, the IRQ mask, the
  // NMI latch and the last SYNC_STAGES+1 pin samples per interrupt line
  // (index 1 is the synced value, index 0 the one before it).
  logic [7:0] m_p;
  logic       m_mask;
  logic       m_pend;
  logic       irq_hist[$];
  logic       nmi_hist[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p    = 8'h34;
    m_mask = 1'b1;
    m_pend = 1'b0;
    irq_hist.delete();
    nmi_hist.delete();
    for (int i = 0; i <= SYNC_STAGES; i++) begin
      irq_hist.push_back(1'b1);
      nmi_hist.push_back(1'b1);
    end
  endtask

  task automatic model_edge();
    logic [7:0] np;
    logic [7:0] en;
    if (!reset_n) begin
      model_reset();
    end else begin
      en = alu_flags_ena & 8'hCF;
      np = m_p;
      if (p_load) np = p_load_data;
      else if (flag_update) np = (m_p & ~en) | (alu_flags_out & en);
      if (int_entry) begin
        np[2] = 1'b1;
`ifdef STATUS_FLAGS_CMOS_DCLR_EN
        np[3] = 1'b0;
`endif
      end
      np = np | 8'h30;
      if (instr_boundary) m_mask = m_p[2];
      if (nmi_hist[0] && !nmi_hist[1]) m_pend = 1'b1;
      else if (int_ack_nmi) m_pend = 1'b0;
      m_p = np;
      irq_hist.push_back(irq_n);
      void'(irq_hist.pop_front());
      nmi_hist.push_back(nmi_n);
      void'(nmi_hist.pop_front());
    end
  endtask

  task automatic check_all();
    logic exp_irq;
    exp_irq = ~irq_hist[1] & ~m_mask;
    check("flags_in", flags_in, m_p);
    check("p_push_data", p_push_data, (m_p & 8'hCF) | 8'h20 | {3'b000, p_push_brk, 4'b0000});
    check("irq_req", {7'b0, irq_req}, {7'b0, exp_irq});
    check("nmi_req", {7'b0, nmi_req}, {7'b0, m_pend});
  endtask

  // Called at a negedge with inputs already set: one edge, then re-check.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    reset_n        = 1'b1;
    alu_flags_out  = 8'h00;
    alu_flags_ena  = 8'h00;
    flag_update    = 1'b0;
    p_load         = 1'b0;
    p_load_data    = 8'h00;
    int_entry      = 1'b0;
    int_ack_nmi    = 1'b0;
    instr_boundary = 1'b0;
  endtask

  initial begin
    idle_inputs();
    p_push_brk = 1'b0;
    irq_n      = 1'b1;
    nmi_n      = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset held for two edges.
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    check("rst_flags_in", flags_in, 8'h34);
    check("rst_push", p_push_data, 8'h24);
    check("rst_irq", {7'b0, irq_req}, 8'h00);
    check("rst_nmi", {7'b0, nmi_req}, 8'h00);

    // ALU merge, then enables ignored without commit.
    flag_update = 1'b1; alu_flags_out = 8'h81; alu_flags_ena = MASK_NZC;
    step();
    check("merge", flags_in, 8'hB5);
    flag_update = 1'b0; alu_flags_out = 8'h00; alu_flags_ena = 8'hFF;
    step();
    check("no_commit", flags_in, 8'hB5);

    // Pull has priority over an ALU update on the same edge.
    p_load = 1'b1; p_load_data = 8'hCB;
    flag_update = 1'b1; alu_flags_ena = 8'hFF; alu_flags_out = 8'h00;
    step();
    check("pull_vs_update", flags_in, 8'hFB);
    idle_inputs();

    // IRQ mask delay: SEI and latch it, then assert IRQ.
    flag_update = 1'b1; alu_flags_ena = MASK_I; alu_flags_out = 8'h04;
    step();
    idle_inputs();
    instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0;
    irq_n = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 1; i++) step();
    check("irq_masked", {7'b0, irq_req}, 8'h00);
    flag_update = 1'b1; alu_flags_ena = MASK_I; alu_flags_out = 8'h00;
    step();
    idle_inputs();
    check("cli_delay", {7'b0, irq_req}, 8'h00);
    step();
    check("cli_delay2", {7'b0, irq_req}, 8'h00);
    instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0;
    check("cli_taken", {7'b0, irq_req}, 8'h01);
    flag_update = 1'b1; alu_flags_ena = MASK_I; alu_flags_out = 8'h04;
    step();
    idle_inputs();
    check("sei_delay", {7'b0, irq_req}, 8'h01);
    step();
    check("sei_delay2", {7'b0, irq_req}, 8'h01);
    instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0;
    check("sei_taken", {7'b0, irq_req}, 8'h00);
    irq_n = 1'b1;

    // NMI latency and no retrigger while held low.
    nmi_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("nmi_lat_%0d", i), {7'b0, nmi_req}, {7'b0, (i >= SYNC_STAGES + 1)});
    end
    int_entry = 1'b1; int_ack_nmi = 1'b1;
    step();
    idle_inputs();
    check("nmi_ack", {7'b0, nmi_req}, 8'h00);
    for (int i = 0; i < 4; i++) step();
    check("nmi_no_retrig", {7'b0, nmi_req}, 8'h00);

    // New edge coincident with the acknowledge keeps NMI pending.
    nmi_n = 1'b1;
    for (int i = 0; i < SYNC_STAGES + 1; i++) step();
    nmi_n = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 1; i++) step();
    check("nmi_pend", {7'b0, nmi_req}, 8'h01);
    nmi_n = 1'b1;
    for (int i = 0; i < SYNC_STAGES + 1; i++) step();
    nmi_n = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) step();
    int_ack_nmi = 1'b1;
    step();
    int_ack_nmi = 1'b0;
    check("nmi_ack_vs_edge", {7'b0, nmi_req}, 8'h01);
    int_ack_nmi = 1'b1;
    step();
    int_ack_nmi = 1'b0;
    nmi_n = 1'b1;

    // Interrupt entry with D=1, I=0.
    p_load = 1'b1; p_load_data = 8'h08;
    step();
    idle_inputs();
    check("d_set", flags_in, 8'h38);
    int_entry = 1'b1; p_push_brk = 1'b1;
    step();
    int_entry = 1'b0;
`ifdef STATUS_FLAGS_CMOS_DCLR_EN
    check("int_entry_p", flags_in, 8'h34);
    check("int_entry_push", p_push_data, 8'h34);
`else
    check("int_entry_p", flags_in, 8'h3C);
    check("int_entry_push", p_push_data, 8'h3C);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n        = ($urandom_range(0, 99) != 0);
      alu_flags_out  = 8'($urandom);
      alu_flags_ena  = 8'($urandom);
      flag_update    = ($urandom_range(0, 1) == 1);
      p_load         = ($urandom_range(0, 7) == 0);
      p_load_data    = 8'($urandom);
      p_push_brk     = ($urandom_range(0, 1) == 1);
      int_entry      = ($urandom_range(0, 7) == 0);
      int_ack_nmi    = ($urandom_range(0, 5) == 0);
      instr_boundary = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) irq_n = ~irq_n;
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
